// File: rtl/pir_axil_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response handshake.
// Optional abort-on-timeout logic is compiled in with `define PIR_AXIL_MASTER_TIMEOUT_EN.
module pir_axil_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_TIMEOUT_CYCLES   = 255
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    // user command
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // user response
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    // AXI4-Lite master
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

    if (C_TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("C_TIMEOUT_CYCLES must be at least 1");
    end

    state_t                            state_q, state_d;
    logic                              aw_pend_q, aw_pend_d;
    logic                              w_pend_q, w_pend_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                        resp_q, resp_d;
    logic                              tmo_q, tmo_d;
    logic                              tmo_hit;

`ifdef PIR_AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active;

    assign active  = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_DATA);
    // cnt_q counts bus cycles already spent, so the abort lands after exactly C_TIMEOUT_CYCLES
    assign tmo_hit = active && (cnt_q == CNT_W'(C_TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && cmd_valid) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    rdata_d = '0;
                    resp_d  = 2'b00;
                    tmo_d   = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (M_AXI_AWREADY) aw_pend_d = 1'b0;
                if (M_AXI_WREADY)  w_pend_d  = 1'b0;
                // both channels may finish in the same cycle or on different ones
                if ((!aw_pend_q || M_AXI_AWREADY) && (!w_pend_q || M_AXI_WREADY)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = RESP;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tmo_hit) begin
            state_d   = RESP;
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            rdata_d   = '0;
            resp_d    = 2'b10;
            tmo_d     = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
        end
    end

    // every VALID/READY is a pure function of registered state
    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = tmo_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_pend_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = w_pend_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == RD_REQ);
    assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_pir_axil_master.sv
// Randomized bench for pir_axil_master: behavioural AXI-Lite slave with programmable ready
// delays, a word-array reference model, and protocol monitors for VALID/payload stability.
module tb_pir_axil_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_timeout, busy;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [3:0]  awaddr, araddr, wstrb;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic        bvalid = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    pir_axil_master #(
        .C_M_AXI_ADDR_WIDTH(4),
        .C_M_AXI_DATA_WIDTH(32),
        .C_TIMEOUT_CYCLES  (16)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWPROT (awprot),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARPROT (arprot),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: four 32-bit words, word 3 answers SLVERR and ignores writes
    logic [31:0] model_mem [4];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // ---------------- behavioural slave ----------------
    logic [31:0] smem [4];
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          proto_err = 0;
    logic        allow_drop = 1'b0, stray = 1'b0, stray_q = 1'b0;
    logic        aw_seen = 1'b0, w_seen = 1'b0, rd_pend = 1'b0;
    logic [3:0]  s_awaddr = '0, s_araddr = '0, s_wstrb = '0;
    logic [31:0] s_wdata = '0;
    logic        hs_aw = 1'b0, hs_w = 1'b0, hs_b = 1'b0, hs_ar = 1'b0, hs_r = 1'b0;
    logic [3:0]  c_awaddr = '0, c_araddr = '0, c_wstrb = '0;
    logic [31:0] c_wdata = '0;
    logic        p_awvalid = 1'b0, p_wvalid = 1'b0, p_arvalid = 1'b0;
    logic [3:0]  p_awaddr = '0, p_araddr = '0, p_wstrb = '0;
    logic [31:0] p_wdata = '0;

    initial begin
        smem[0] = 32'h0000_0000; smem[1] = 32'hDEAD_BEEF;
        smem[2] = 32'h1234_5678; smem[3] = 32'hA5A5_A5A5;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_seen = 0; w_seen = 0; rd_pend = 0;
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            end else begin
                // effects of handshakes completed at the preceding rising edge
                if (hs_aw) begin aw_cnt++; aw_seen = 1; s_awaddr = c_awaddr; end
                if (hs_w)  begin w_cnt++; w_seen = 1; s_wdata = c_wdata; s_wstrb = c_wstrb; end
                if (hs_b)  begin b_cnt++; bvalid = 0; end
                if (hs_ar) begin ar_cnt++; rd_pend = 1; s_araddr = c_araddr; r_wait = 0; end
                if (hs_r)  begin r_cnt++; rvalid = 0; end

                if (p_awvalid && !hs_aw && (!awvalid || awaddr !== p_awaddr)) proto_err++;
                if (p_wvalid && !hs_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb))
                    proto_err++;
                if (p_arvalid && !hs_ar && !allow_drop && (!arvalid || araddr !== p_araddr))
                    proto_err++;
                if ((awvalid && awprot !== 3'b000) || (arvalid && arprot !== 3'b000)) proto_err++;
                if (cmd_ready && busy) proto_err++;

                awready = awvalid && (aw_wait >= aw_delay);
                aw_wait = awvalid ? aw_wait + 1 : 0;
                wready  = wvalid && (w_wait >= w_delay);
                w_wait  = wvalid ? w_wait + 1 : 0;
                arready = arvalid && (ar_wait >= ar_delay);
                ar_wait = arvalid ? ar_wait + 1 : 0;

                if (aw_seen && w_seen && !bvalid) begin
                    if (b_wait >= b_delay) begin
                        bvalid = 1;
                        if (s_awaddr[3:2] == 2'd3) begin
                            bresp = 2'b10;
                        end else begin
                            bresp = 2'b00;
                            smem[s_awaddr[3:2]] = merge(smem[s_awaddr[3:2]], s_wdata, s_wstrb);
                        end
                        aw_seen = 0; w_seen = 0; b_wait = 0;
                    end else begin
                        b_wait++;
                    end
                end
                if (rd_pend && !rvalid) begin
                    if (r_wait >= r_delay) begin
                        rvalid  = 1;
                        rdata   = smem[s_araddr[3:2]];
                        rresp   = (s_araddr[3:2] == 2'd3) ? 2'b10 : 2'b00;
                        rd_pend = 0;
                    end else begin
                        r_wait++;
                    end
                end
                if (stray) begin
                    bvalid = 1; rvalid = 1; rdata = 32'hBAD0_BAD0;
                end else if (stray_q) begin
                    bvalid = 0; rvalid = 0;
                end
                stray_q = stray;

                hs_aw = awvalid && awready; c_awaddr = awaddr;
                hs_w  = wvalid && wready;   c_wdata = wdata; c_wstrb = wstrb;
                hs_b  = bvalid && bready;
                hs_ar = arvalid && arready; c_araddr = araddr;
                hs_r  = rvalid && rready;
                p_awvalid = awvalid; p_awaddr = awaddr;
                p_wvalid = wvalid; p_wdata = wdata; p_wstrb = wstrb;
                p_arvalid = arvalid; p_araddr = araddr;
            end
        end
    end

    // ---------------- one complete command/response transaction ----------------
    task automatic do_txn(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold);
        int          n;
        int          aw0, w0, b0, ar0, r0;
        logic [31:0] exp_rd, held_rd;
        logic [1:0]  exp_resp;
        logic        hold_bad;
        exp_resp = (a[3:2] == 2'd3) ? 2'b10 : 2'b00;
        if (wr) begin
            exp_rd = '0;
            if (exp_resp == 2'b00) model_mem[a[3:2]] = merge(model_mem[a[3:2]], d, s);
        end else begin
            exp_rd = model_mem[a[3:2]];
        end
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;

        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        cmd_valid = 0;
        check("busy_after_accept", 64'(busy), 64'd1);
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check("rsp_arrive", 64'(n < 200), 64'd1);

        held_rd  = rsp_rdata;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== held_rd || cmd_ready !== 1'b0) hold_bad = 1;
        end
        check("rsp_hold", 64'(hold_bad), 64'd0);
        check(wr ? "wr_rdata" : "rd_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check(wr ? "wr_resp" : "rd_resp", 64'(rsp_resp), 64'(exp_resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'd0);

        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("idle_after_rsp", 64'({rsp_valid, busy, cmd_ready}), 64'b001);
        @(negedge clk);
        check("hs_counts", 64'({4'(aw_cnt - aw0), 4'(w_cnt - w0), 4'(b_cnt - b0),
                                4'(ar_cnt - ar0), 4'(r_cnt - r0)}),
              wr ? 64'h11100 : 64'h00011);
        if (wr) check("aw_w_payload", {24'd0, s_awaddr, s_wdata, s_wstrb}, {24'd0, a, d, s});
        else    check("ar_payload", 64'(s_araddr), 64'(a));
    endtask

    initial begin
        logic bad;
        int   cyc;
        model_mem[0] = 32'h0000_0000; model_mem[1] = 32'hDEAD_BEEF;
        model_mem[2] = 32'h1234_5678; model_mem[3] = 32'hA5A5_A5A5;

        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy,
                               rsp_timeout}), 64'd0);
        check("rst_data", {26'd0, rsp_resp, rsp_rdata, awaddr}, 64'd0);
        rst = 0;
        @(negedge clk);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // late AW/W ready write of the enable bit, then read back
        aw_delay = 1; w_delay = 1;
        do_txn(1'b1, 4'h0, 32'h0000_0002, 4'hF, 0);
        aw_delay = 0; w_delay = 0;
        do_txn(1'b0, 4'h0, 32'h0, 4'h0, 0);
        do_txn(1'b0, 4'h4, 32'h0, 4'h0, 0);
        // W handshake well after AW
        w_delay = 3;
        do_txn(1'b1, 4'h8, 32'hCAFE_F00D, 4'h5, 0);
        w_delay = 0;
        // response back-pressure
        do_txn(1'b0, 4'h8, 32'h0, 4'h0, 5);

        for (int t = 0; t < 40; t++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

        // stray B/R beats while idle must not be taken
        cyc = b_cnt + r_cnt;
        stray = 1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bready || rready || busy || rsp_valid) bad = 1;
        end
        stray = 0;
        repeat (2) @(negedge clk);
        check("stray_ignored", 64'({bad, 8'(b_cnt + r_cnt - cyc)}), 64'd0);

        // reset in the middle of a write request
        aw_delay = 6; w_delay = 6;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 0;
        check("mid_wr_valid", 64'({awvalid, wvalid}), 64'b11);
        #2 rst = 1;
        #1 check("rst_async", 64'({awvalid, wvalid, busy, rsp_valid}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        aw_delay = 0; w_delay = 0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) bad = 1;
        end
        check("no_rsp_after_abort", 64'(bad), 64'd0);
        do_txn(1'b0, 4'h4, 32'h0, 4'h0, 1);

`ifdef PIR_AXIL_MASTER_TIMEOUT_EN
        ar_delay   = 1000;
        allow_drop = 1;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h4;
        @(negedge clk);
        cmd_valid = 0;
        cyc = 0;
        for (int n = 0; n < 100 && !rsp_valid; n++) begin
            if (arvalid) cyc++;
            @(negedge clk);
        end
        check("tmo_arvalid_cycles", 64'(cyc), 64'd16);
        check("tmo_rsp", {29'd0, rsp_valid, rsp_resp, rsp_timeout, rsp_rdata},
              {29'd0, 1'b1, 2'b10, 1'b1, 32'd0});
        check("tmo_axi_quiet", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready  = 0;
        ar_delay   = 0;
        allow_drop = 0;
        @(negedge clk);
        do_txn(1'b0, 4'h4, 32'h0, 4'h0, 0);
`endif

        check("protocol_monitor", 64'(proto_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pir_axil_master.md
PIR_AXIL_MASTER -- requirements
Module: pir_axil_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width.
REQ-003 SHALL have parameter C_TIMEOUT_CYCLES, default 255, cycles before abort (timeout build only).
REQ-004 SHALL have port M_AXI_ACLK, in, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port M_AXI_ARESET, in, 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR, cmd_wdata in DATA, cmd_wstrb in DATA/8: user command.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA, rsp_resp out 2, rsp_timeout out 1, busy out 1: user response.
REQ-008 SHALL have AXI4-Lite master ports AWADDR/AWPROT/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in.
REQ-009 SHALL have AXI4-Lite master ports BRESP/BVALID in, BREADY out; ARADDR/ARPROT/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out; all prefixed M_AXI_.

Function
REQ-010 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP; one transaction outstanding.
REQ-011 SHALL drive cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready; latch addr/wdata/wstrb/write.
REQ-012 SHALL transition IDLE->WR_REQ (cmd_write=1) or IDLE->RD_REQ (cmd_write=0) on accept.
REQ-013 SHALL, in WR_REQ, assert AWVALID and WVALID together on the first cycle, and drop each independently the cycle after its own VALID&&READY.
REQ-014 SHALL never make VALID depend on READY, and SHALL hold ADDR/DATA/STRB stable while VALID is high.
REQ-015 SHALL enter WR_RESP once both AW and W handshakes are complete (same or different cycles); assert BREADY; capture BRESP on BVALID&&BREADY; go RESP.
REQ-016 SHALL, in RD_REQ, assert ARVALID until ARVALID&&ARREADY, then enter RD_DATA with RREADY=1; capture RDATA/RRESP on RVALID&&RREADY; go RESP.
REQ-017 SHALL drive AWPROT=ARPROT=3'b000.
REQ-018 SHALL hold rsp_valid=1 in RESP until rsp_valid&&rsp_ready, then return to IDLE; rsp_rdata=0 for writes.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL ignore a BVALID/RVALID arriving outside WR_RESP/RD_DATA (READY stays 0).
REQ-021 SHALL accept the next command at the earliest on the cycle after the RESP handshake; no command is accepted in the same cycle as rsp handshake.

Reset
REQ-022 SHALL, on M_AXI_ARESET=1, immediately force IDLE, all AXI VALID/READY outputs 0, rsp_valid=0, rsp_timeout=0, busy=0, rsp_rdata=0, rsp_resp=0, addresses/data 0.
REQ-023 SHALL abandon any in-flight transaction on reset without issuing a response; cmd_ready=1 from the first clock after reset release.

Configuration
REQ-024 SHALL compile timeout logic only when macro PIR_AXIL_MASTER_TIMEOUT_EN is defined.
REQ-025 With PIR_AXIL_MASTER_TIMEOUT_EN: counter cleared on command accept, increments each cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA; on reaching C_TIMEOUT_CYCLES, drop all AXI VALID/READY, go RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-026 Without PIR_AXIL_MASTER_TIMEOUT_EN: no counter, FSM waits indefinitely, rsp_timeout tied 0.

Verification
REQ-027 Write cmd addr=0x0 wdata=0x00000002 wstrb=0xF to slave responding AWREADY/WREADY one cycle late -> one AW and one W handshake, rsp_resp=2'b00, rsp_rdata=0, slave enable bit set.
REQ-028 Read cmd addr=0x4 -> one AR handshake, rsp_rdata=0xDEADBEEF, rsp_resp=2'b00.
REQ-029 Write with WREADY asserted 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held with stable WDATA until its handshake, exactly one B handshake.
REQ-030 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable 5 cycles, cmd_ready=0 throughout, IDLE after handshake.
REQ-031 Timeout build, C_TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_resp=2'b10, rsp_timeout=1.
REQ-032 Assert M_AXI_ARESET mid-WR_REQ -> AWVALID/WVALID fall 0 without a clock edge, no rsp_valid, cmd_ready=1 after release.
